// File: rtl/user_pixel_pkg.sv
// Shared types and defaults for the pixel fetch block: FSM state encoding,
// parameter defaults and the little-endian byte selector.
package user_pixel_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMemReq,
    StMemWait,
    StResp
  } fetch_state_e;

  localparam logic [31:0] BaseAddrDefault   = 32'h1000_0000;
  localparam int unsigned StatsWidthDefault = 16;

  // Byte 0 lives in the least significant lane.
  function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/user_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module user_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + Width'(1);
    end
  end

endmodule

// File: rtl/user_pixel_fetch.sv
// Pixel fetch with a one-word cache in front of a read-only OBI-style master.
// Hit/miss statistics are built only when USER_PIXEL_FETCH_STATS_EN is defined.
module user_pixel_fetch
  import user_pixel_pkg::*;
#(
  parameter logic [31:0] BaseAddr   = BaseAddrDefault,
  parameter int unsigned StatsWidth = StatsWidthDefault
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pix_req_i,
  input  logic [31:0]           pix_addr_i,
  output logic [7:0]            pix_data_o,
  output logic                  pix_valid_o,
  output logic                  pix_err_o,
  input  logic                  flush_i,
`ifdef USER_PIXEL_FETCH_STATS_EN
  output logic [StatsWidth-1:0] hit_cnt_o,
  output logic [StatsWidth-1:0] miss_cnt_o,
`endif
  output logic                  mem_req_o,
  output logic [31:0]           mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_err_i
);

  if (StatsWidth < 1) begin : gen_bad_stats_width
    $error("StatsWidth must be at least 1");
  end

  fetch_state_e state_q;

  logic        cache_valid_q;
  logic [29:0] cache_tag_q;
  logic [31:0] cache_data_q;

  // Outstanding miss: word tag and byte lane, latched when the request leaves IDLE.
  logic [29:0] req_tag_q;
  logic [1:0]  req_byte_q;

  logic hit;

  // A flush in the lookup cycle forces a miss.
  assign hit = cache_valid_q && (cache_tag_q == pix_addr_i[31:2]) && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
      req_tag_q     <= '0;
      req_byte_q    <= '0;
      pix_data_o    <= '0;
      pix_valid_o   <= 1'b0;
      pix_err_o     <= 1'b0;
      mem_req_o     <= 1'b0;
      mem_addr_o    <= '0;
    end else begin
      pix_valid_o <= 1'b0;
      pix_err_o   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (pix_req_i) begin
            if (hit) begin
              pix_data_o  <= sel_byte(cache_data_q, pix_addr_i[1:0]);
              pix_valid_o <= 1'b1;
              state_q     <= StResp;
            end else begin
              req_tag_q  <= pix_addr_i[31:2];
              req_byte_q <= pix_addr_i[1:0];
              mem_addr_o <= BaseAddr + {pix_addr_i[31:2], 2'b00};
              mem_req_o  <= 1'b1;
              state_q    <= StMemReq;
            end
          end
        end

        // Request is held until granted even if the consumer lets go.
        StMemReq: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state_q   <= StMemWait;
          end
        end

        StMemWait: begin
          if (mem_rvalid_i) begin
            pix_valid_o <= 1'b1;
            state_q     <= StResp;
            if (mem_err_i) begin
              pix_data_o    <= 8'hFF;
              pix_err_o     <= 1'b1;
              cache_valid_q <= 1'b0;
            end else begin
              pix_data_o    <= sel_byte(mem_rdata_i, req_byte_q);
              cache_tag_q   <= req_tag_q;
              cache_data_q  <= mem_rdata_i;
              cache_valid_q <= 1'b1;
            end
          end
        end

        // Bubble cycle: no lookup, lets the consumer move its address on.
        StResp: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase

      // Flush beats a coincident fill.
      if (flush_i) begin
        cache_valid_q <= 1'b0;
      end
    end
  end

`ifdef USER_PIXEL_FETCH_STATS_EN
  logic lookup;

  assign lookup = (state_q == StIdle) && pix_req_i;

  user_sat_counter #(
    .Width(StatsWidth)
  ) u_hit_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(flush_i),
    .inc_i(lookup && hit),
    .cnt_o(hit_cnt_o)
  );

  user_sat_counter #(
    .Width(StatsWidth)
  ) u_miss_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(flush_i),
    .inc_i(lookup && !hit),
    .cnt_o(miss_cnt_o)
  );
`endif

endmodule
